spi_slave: RTL and testbench

- SPI peripheral (responder), the far end of the team's `spi` master.
- Oversamples sck/cs/mosi in the system clk domain; no sck-domain logic.
- Shifts in an len-bit word from mosi and shifts out a preloaded word on miso.
- Used for master loopback/system tests and as a register-port front end.

---
 rtl/spi_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI responder oversampled in the clk domain: captures len bits from mosi and
// returns a word latched at cs fall on miso. Optional macro: SPI_SLAVE_LSB_FIRST_EN.
module spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic [4:0]   len,
    input  logic [W-1:0] tx_data,
    input  logic         sck,
    input  logic         cs,
    input  logic         mosi,
    output logic         miso,
    output logic         miso_oe,
    output logic [W-1:0] rx_data,
    output logic         valid,
    output logic         busy,
    output logic         abort
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    // Index 0 = sck, 1 = cs, 2 = mosi.
    logic [2:0]             in_async;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [SYNC_STAGES-1:0] sync_d [3];
    logic                   hist_q [3];
    logic                   hist_d [3];

    assign in_async = {mosi, cs, sck};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], in_async[i]};
            hist_d[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // cs resets as "low" so a frame can only start after cs has been seen high.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q[gi] <= '0;
                    hist_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_d[gi];
                    hist_q[gi] <= hist_d[gi];
                end
            end
        end
    endgenerate

    logic sck_now, cs_now, mosi_now;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_now  = sync_q[0][SYNC_STAGES-1];
    assign cs_now   = sync_q[1][SYNC_STAGES-1];
    assign mosi_now = sync_q[2][SYNC_STAGES-1];
    assign sck_rise =  sck_now & ~hist_q[0];
    assign sck_fall = ~sck_now &  hist_q[0];
    assign cs_rise  =  cs_now  & ~hist_q[1];
    assign cs_fall  = ~cs_now  &  hist_q[1];

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [5:0]     len_q, len_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   tx_q, tx_d;
    logic [W-1:0]   rx_sr_q, rx_sr_d;
    logic [W-1:0]   rx_data_q, rx_data_d;
    logic           miso_q, miso_d;
    logic           miso_oe_q, miso_oe_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           abort_q, abort_d;

    logic [5:0]     len_in;
    logic [5:0]     cnt_inc;
    logic           last_bit;
    logic           lead_fall;
    logic           advance;
    logic [IW-1:0]  first_idx;
    logic [IW-1:0]  next_idx;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    logic [IW-1:0]  rx_idx;
`endif

    assign len_in    = (len == 5'd0) ? 6'd32 : {1'b0, len};
    assign cnt_inc   = cnt_q + 6'd1;
    assign last_bit  = sck_rise && (cnt_inc == len_q);
    // Only mode 3 can present a falling edge before the first bit.
    assign lead_fall = mode_q && (cnt_q == 6'd0);
    assign advance   = sck_fall && !lead_fall && (cnt_q != 6'd0);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign first_idx = '0;
    assign next_idx  = IW'(cnt_q);
    assign rx_idx    = IW'(len_q - 6'd1 - cnt_q);
`else
    assign first_idx = IW'(len_in - 6'd1);
    assign next_idx  = IW'(len_q - 6'd1 - cnt_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        miso_d    = miso_q;
        miso_oe_d = miso_oe_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    len_d     = len_in;
                    mode_d    = mode;
                    tx_d      = tx_data;
                    cnt_d     = 6'd0;
                    rx_sr_d   = '0;
                    miso_d    = tx_data[first_idx];
                    miso_oe_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sck_rise) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                    rx_sr_d[rx_idx] = mosi_now;
`else
                    rx_sr_d = {rx_sr_q[W-2:0], mosi_now};
`endif
                    cnt_d = cnt_inc;
                    if (last_bit) begin
                        miso_d  = 1'b0;
                        state_d = S_LATCH;
                    end
                end else if (advance) begin
                    miso_d = tx_q[next_idx];
                end
                // A final bit sampled together with cs rise still completes the frame.
                if (cs_rise && !last_bit) begin
                    abort_d   = 1'b1;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_LATCH: begin
                rx_data_d = rx_sr_q;
                valid_d   = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (cs_now) begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            len_q     <= 6'd0;
            mode_q    <= 1'b0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            miso_q    <= miso_d;
            miso_oe_q <= miso_oe_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            abort_q   <= abort_d;
        end
    end

    assign miso    = miso_q;
    assign miso_oe = miso_oe_q;
    assign rx_data = rx_data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign abort   = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the SPI master at sck = clk/10
// and a background process checks outputs every clk against a frame-level model.
module tb_spi_slave;

    localparam int W    = 32;
    localparam int HALF = 50;   // sck half period = 5 clk periods

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [4:0]   len;
    logic [W-1:0] tx_data;
    logic         sck;
    logic         cs;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [W-1:0] rx_data;
    logic         valid;
    logic         busy;
    logic         abort;

    spi_slave #(.SYNC_STAGES(2), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .len     (len),
        .tx_data (tx_data),
        .sck     (sck),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .rx_data (rx_data),
        .valid   (valid),
        .busy    (busy),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          valid_cnt = 0;
    int          abort_cnt = 0;
    bit          abort_allowed = 1'b0;
    bit          valid_prev = 1'b0;
    logic [31:0] exp_rx = '0;
    logic [31:0] rx_hold = '0;
    logic [31:0] got;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mask_of(input int l);
        logic [63:0] m;
        m = (64'd1 << l) - 64'd1;
        return m[31:0];
    endfunction

    // Per-cycle checks against the frame-level model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_hold    = '0;
                valid_prev = 1'b0;
            end else begin
                check(miso_oe || !miso, "miso_zero_when_not_oe", {31'd0, miso}, 32'd0);
                if (valid) begin
                    valid_cnt++;
                    check(rx_data == exp_rx, "rx_on_valid", rx_data, exp_rx);
                    check(!valid_prev, "valid_single_cycle", {31'd0, valid_prev}, 32'd0);
                    rx_hold = exp_rx;
                end else begin
                    check(rx_data == rx_hold, "rx_held", rx_data, rx_hold);
                end
                if (abort) begin
                    abort_cnt++;
                    check(abort_allowed, "abort_expected", {31'd0, abort}, {31'd0, abort_allowed});
                end
                valid_prev = valid;
            end
        end
    end

    // One master transaction: ncyc sck cycles, optional reset after rst_at cycles.
    task automatic frame(input logic m, input logic [4:0] l, input logic [31:0] tx,
                         input logic [31:0] data, input int ncyc, input int rst_at,
                         input string tag, output logic [31:0] rxw);
        int   nbits;
        int   v0;
        int   a0;
        bit   exp_valid;
        bit   exp_abort;
        logic b;
        nbits     = (l == 5'd0) ? 32 : int'(l);
        exp_valid = (rst_at < 0) && (ncyc >= nbits);
        exp_abort = (rst_at < 0) && (ncyc < nbits);
        exp_rx    = data & mask_of(nbits);
        abort_allowed = exp_abort;
        v0  = valid_cnt;
        a0  = abort_cnt;
        rxw = '0;
        mode = m; len = l; tx_data = tx; sck = m; mosi = 1'b0;
        #30;
        cs = 1'b0;
        #HALF;
        check(busy && miso_oe, "selected_after_cs_fall", {30'd0, busy, miso_oe}, 32'd3);
        for (int i = 0; i < ncyc; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                #20;
                rst = 1'b0;
                #10;
                check({miso, miso_oe, valid, busy, abort} == 5'd0, "reset_mid_frame_ctrl",
                      {27'd0, miso, miso_oe, valid, busy, abort}, 32'd0);
                check(rx_data == 32'd0, "reset_mid_frame_rx", rx_data, 32'd0);
                break;
            end
`ifdef SPI_SLAVE_LSB_FIRST_EN
            b = (i < nbits) ? data[i] : (i % 2 == 0);
`else
            b = (i < nbits) ? data[nbits-1-i] : (i % 2 == 0);
`endif
            if (m) begin
                sck = 1'b0;
                mosi = b;
            end else begin
                mosi = b;
            end
            #HALF;
            if (i < nbits) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                rxw[i] = miso;
`else
                rxw[nbits-1-i] = miso;
`endif
            end else begin
                check(miso == 1'b0, "miso_extra_clock", {31'd0, miso}, 32'd0);
            end
            sck = 1'b1;
            #HALF;
            if (!m) sck = 1'b0;
        end
        #HALF;
        cs = 1'b1;
        #120;
        check(valid_cnt - v0 == int'(exp_valid), "valid_count",
              valid_cnt - v0, {31'd0, exp_valid});
        check(abort_cnt - a0 == int'(exp_abort), "abort_count",
              abort_cnt - a0, {31'd0, exp_abort});
        check(!busy && !miso_oe, "released_after_cs_rise", {30'd0, busy, miso_oe}, 32'd0);
        if (exp_valid)
            check(rxw == (tx & mask_of(nbits)), "master_rx", rxw, tx & mask_of(nbits));
        abort_allowed = 1'b0;
        $display("[TB] frame %s: rx_data=%h master_rx=%h valids=%0d aborts=%0d",
                 tag, rx_data, rxw, valid_cnt - v0, abort_cnt - a0);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        mode = 1'b0; len = 5'd0; tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check({miso, miso_oe, valid, busy, abort} == 5'd0, "reset_ctrl",
              {27'd0, miso, miso_oe, valid, busy, abort}, 32'd0);
        check(rx_data == 32'd0, "reset_rx", rx_data, 32'd0);
        rst = 1'b0;
        #100;

        frame(1'b1, 5'd16, 32'h0000A5C3, 32'h00000081, 16, -1, "mode3_len16", got);
        check(rx_data == 32'h00000081, "lit_mode3_rx", rx_data, 32'h00000081);
        check(got == 32'h0000A5C3, "lit_mode3_master", got, 32'h0000A5C3);

        frame(1'b0, 5'd8, 32'h0000003C, 32'h000000F0, 8, -1, "mode0_len8", got);
        check(rx_data == 32'h000000F0, "lit_len8_rx", rx_data, 32'h000000F0);
        check(got == 32'h0000003C, "lit_len8_master", got, 32'h0000003C);

        frame(1'b0, 5'd0, 32'hDEADBEEF, 32'h12345678, 32, -1, "len32", got);
        check(rx_data == 32'h12345678, "lit_len32_rx", rx_data, 32'h12345678);
        check(got == 32'hDEADBEEF, "lit_len32_master", got, 32'hDEADBEEF);

        frame(1'b0, 5'd16, 32'h0000A5C3, 32'h00000081, 5, -1, "abort_after5", got);
        check(rx_data == 32'h12345678, "lit_abort_rx_kept", rx_data, 32'h12345678);

        frame(1'b0, 5'd16, 32'h00001234, 32'h00000081, 16, 7, "reset_after7", got);
        check(rx_data == 32'h00000000, "lit_reset_rx", rx_data, 32'h00000000);

        frame(1'b0, 5'd16, 32'h0000A5C3, 32'h00000081, 16, -1, "post_reset", got);
        check(rx_data == 32'h00000081, "lit_post_reset_rx", rx_data, 32'h00000081);

        frame(1'b0, 5'd16, 32'h00005A5A, 32'h00000081, 20, -1, "extra_clocks", got);
        check(rx_data == 32'h00000081, "lit_extra_rx", rx_data, 32'h00000081);
        check(got == 32'h00005A5A, "lit_extra_master", got, 32'h00005A5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
